// File: rtl/regfile_pkg.sv
// Shared defaults and clear-FSM state type for the multi-read-port register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned NRD_DEF    = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: write-first bypass, sweep masking and optional zero-register masking.
// Optional feature: REGFILE_ZERO_REG_EN forces address 0 to read as zero.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clearing,
    input  logic              re_n,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              wr_fwd,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    always_comb begin
        rdata_d = rdata_q;
        if (!re_n) begin
            if (clearing) begin
                rdata_d = '0;
            end else if (wr_fwd && (waddr == raddr)) begin
                rdata_d = wdata;
            end else begin
                rdata_d = mem_rdata;
            end
`ifdef REGFILE_ZERO_REG_EN
            // Masking last also hides any bypassed write to address 0.
            if (raddr == '0) begin
                rdata_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a post-reset clear sweep (busy while sweeping).
// Optional feature: REGFILE_ZERO_REG_EN makes address 0 a hard-wired zero register.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NRD    = NRD_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [NRD-1:0]        re_,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic                  busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    clr_state_e        state_d, state_q;
    logic [ADDR_W-1:0] cnt_d, cnt_q;
    logic              busy_d, busy_q;

    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic              wr_fwd_c;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Clear sweep sequencing and selection of the single memory write port.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = waddr;
        mem_wdata_c = wdata;
        wr_fwd_c    = 1'b0;
        unique case (state_q)
            CLEAR: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = cnt_q;
                mem_wdata_c = '0;
                if (&cnt_q) begin
                    state_d = READY;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            READY: begin
                wr_fwd_c = !we_;
                mem_we_c = !we_;
`ifdef REGFILE_ZERO_REG_EN
                if (waddr == '0) begin
                    mem_we_c = 1'b0;
                end
`endif
            end
            default: ;
        endcase
        if (reset) begin
            mem_we_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Storage has no reset; only the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_rdport #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W)
        ) u_rdport (
            .clk      (clk),
            .reset    (reset),
            .clearing (state_q == CLEAR),
            .re_n     (re_[k]),
            .raddr    (raddr[k*ADDR_W +: ADDR_W]),
            .mem_rdata(mem_q[raddr[k*ADDR_W +: ADDR_W]]),
            .wr_fwd   (wr_fwd_c),
            .waddr    (waddr),
            .wdata    (wdata),
            .rdata    (rdata[k*DATA_W +: DATA_W])
        );
    end

    assign busy = busy_q;

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NRD, default 2, number of independent read ports (1..4).
REQ-004 clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 we_  in  1  active-low write enable.
REQ-007 waddr  in  ADDR_W  write address.
REQ-008 wdata  in  DATA_W  write data.
REQ-009 re_  in  NRD  active-low read enable, one bit per port.
REQ-010 raddr  in  NRD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-011 rdata  out  NRD*DATA_W  registered read data; port k occupies bits [k*DATA_W +: DATA_W].
REQ-012 busy  out  1  high while the post-reset clear sweep runs.

Function
REQ-013 Read latency SHALL be exactly one cycle: re_[k]=0 at edge N loads rdata port k at edge N with the entry at raddr[k].
REQ-014 With re_[k]=1, rdata port k SHALL hold its previous value.
REQ-015 Write with we_=0 and busy=0 SHALL update mem[waddr] at the edge.
REQ-016 Same-cycle write and read to the same address SHALL return the new wdata (write-first bypass), independently on every port.
REQ-017 Reads on different ports to the same address in one cycle SHALL return identical data.
REQ-018 The clear FSM SHALL have two states: CLEAR (busy=1) and READY (busy=0).
REQ-019 In CLEAR, one entry per cycle SHALL be zeroed, from address 0 upward, using an ADDR_W-bit counter.
REQ-020 CLEAR->READY SHALL occur at the edge that zeroes address DEPTH-1; the sweep takes exactly DEPTH cycles after reset deasserts.
REQ-021 In CLEAR, writes SHALL be ignored, and enabled reads SHALL load 0.
REQ-022 The clear counter SHALL not wrap into a second sweep; READY persists until the next reset.

Reset
REQ-023 reset=1 at an edge SHALL force state CLEAR, clear counter = 0, busy=1, all rdata = 0.
REQ-024 Reset asserted mid-sweep SHALL restart the sweep from address 0.
REQ-025 Memory contents SHALL not be cleared by reset directly; only by the sweep.

Configuration
REQ-026 Macro REGFILE_ZERO_REG_EN defined: address 0 SHALL always read 0, and writes to address 0 SHALL be discarded, including through the bypass path.
REQ-027 Macro undefined: address 0 SHALL behave as an ordinary entry.

Structure
REQ-028 Package regfile_pkg SHALL hold the default DATA_W/ADDR_W/NRD constants and the clear-FSM state typedef (CLEAR, READY).
REQ-029 Sub-module regfile_rdport SHALL implement one read port: the bypass compare, the output register, and zero-reg masking. It is instantiated NRD times through a generate loop.

Verification
REQ-030 Reset for 1 cycle, DEPTH=32 -> busy high for exactly 32 cycles after deassert; a read of any address then returns 0.
REQ-031 Write 0xDEADBEEF to address 7, then read address 7 on ports 0 and 1 in the next cycle -> both return 0xDEADBEEF one cycle later.
REQ-032 Write 0x12345678 to address 3 while port 1 reads address 3 in the same cycle -> port 1 returns 0x12345678.
REQ-033 Write 0xA5A5A5A5 during CLEAR at address 31 -> after READY, a read of address 31 returns 0.
REQ-034 Assert reset at sweep cycle 10 -> busy stays high for a further 32 cycles after deassert.
REQ-035 With REGFILE_ZERO_REG_EN, write 0xFFFFFFFF to address 0 with same-cycle read -> returns 0, now and on a later read.
